// File: rtl/riscv_id_imm_unit_if.sv
// riscv_id_imm_unit_if: input (decode request) and output (immediate) valid/ready channels of the immediate unit.
// master = surrounding pipeline, slave = the immediate unit.
interface riscv_id_imm_unit_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int TAG_WIDTH   = 4
);
  logic                   i_valid;
  logic                   o_ready;
  logic [2:0]             i_imm;
  logic [INSTR_WIDTH-1:0] i_instr;
  logic [TAG_WIDTH-1:0]   i_tag;
  logic                   o_valid;
  logic                   i_ready;
  logic [DATA_WIDTH-1:0]  o_imm_data;
  logic                   o_imm_err;
  logic [TAG_WIDTH-1:0]   o_tag;

  modport master (
    output i_valid, i_imm, i_instr, i_tag, i_ready,
    input  o_ready, o_valid, o_imm_data, o_imm_err, o_tag
  );

  modport slave (
    input  i_valid, i_imm, i_instr, i_tag, i_ready,
    output o_ready, o_valid, o_imm_data, o_imm_err, o_tag
  );
endinterface

// File: rtl/riscv_id_imm_unit.sv
// riscv_id_imm_unit: ID-stage immediate generator, 1-cycle latency, 2-entry skid buffer for full throughput.
// Optional feature macro RISCV_IMM_ZIMM_EN enables the CSR zimm select (IMM_Z_TYPE).
//
// state | meaning
// EMPTY | nothing held, o_valid=0, o_ready=1
// ONE   | main register M holds the output beat, o_ready=1
// TWO   | M holds the output beat, skid register S holds the next, o_ready=0
module riscv_id_imm_unit #(
  parameter int DATA_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  riscv_id_imm_unit_if.slave    bus
);

  localparam logic [2:0] IMM_I_TYPE = 3'd0;
  localparam logic [2:0] IMM_S_TYPE = 3'd1;
  localparam logic [2:0] IMM_B_TYPE = 3'd2;
  localparam logic [2:0] IMM_U_TYPE = 3'd3;
  localparam logic [2:0] IMM_J_TYPE = 3'd4;
  localparam logic [2:0] IMM_Z_TYPE = 3'd5;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t                 state, state_nxt;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   sb;
  logic [DATA_WIDTH-1:0]  imm_u;
  logic [DATA_WIDTH-1:0]  dec_data;
  logic                   dec_err;
  logic                   unused_instr;

  logic                   rdy_en;
  logic                   out_valid, st_ready;
  logic                   in_fire, out_fire;
  logic                   load_m_in, load_m_skid, load_s;

  logic [DATA_WIDTH-1:0]  m_data, s_data;
  logic                   m_err, s_err;
  logic [TAG_WIDTH-1:0]   m_tag, s_tag;

  assign instr        = bus.i_instr;
  assign sb           = instr[31];
  assign unused_instr = ^instr[6:0];

  // U-type already fills 32 bits, so the sign fill only exists on wider datapaths.
  if (DATA_WIDTH > 32) begin : g_u_wide
    assign imm_u = {{(DATA_WIDTH-32){sb}}, instr[31:12], 12'h000};
  end else begin : g_u_narrow
    assign imm_u = {instr[31:12], 12'h000};
  end

  always_comb begin
    dec_data = '0;
    dec_err  = 1'b0;
    case (bus.i_imm)
      IMM_I_TYPE: dec_data = {{(DATA_WIDTH-12){sb}}, instr[31:20]};
      IMM_S_TYPE: dec_data = {{(DATA_WIDTH-12){sb}}, instr[31:25], instr[11:7]};
      IMM_B_TYPE: dec_data = {{(DATA_WIDTH-13){sb}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
      IMM_U_TYPE: dec_data = imm_u;
      IMM_J_TYPE: dec_data = {{(DATA_WIDTH-21){sb}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
`ifdef RISCV_IMM_ZIMM_EN
      IMM_Z_TYPE: dec_data = {{(DATA_WIDTH-5){1'b0}}, instr[19:15]};
`else
      IMM_Z_TYPE: dec_err  = 1'b1;
`endif
      default:    dec_err  = 1'b1;
    endcase
  end

  assign in_fire  = bus.i_valid & bus.o_ready;
  assign out_fire = out_valid & bus.i_ready;

  // Holds o_ready low until the first clock edge after reset release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (in_fire) state_nxt = ST_ONE;
      ST_ONE: begin
        if (in_fire && !out_fire)      state_nxt = ST_TWO;
        else if (!in_fire && out_fire) state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (out_fire) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid   = 1'b0;
    st_ready    = 1'b0;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    case (state)
      ST_EMPTY: begin
        st_ready  = 1'b1;
        load_m_in = in_fire;
      end
      ST_ONE: begin
        out_valid = 1'b1;
        st_ready  = 1'b1;
        load_m_in = in_fire & out_fire;
        load_s    = in_fire & ~out_fire;
      end
      ST_TWO: begin
        out_valid   = 1'b1;
        load_m_skid = out_fire;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_data <= '0;
      m_err  <= 1'b0;
      m_tag  <= '0;
      s_data <= '0;
      s_err  <= 1'b0;
      s_tag  <= '0;
    end else begin
      if (load_m_in) begin
        m_data <= dec_data;
        m_err  <= dec_err;
        m_tag  <= bus.i_tag;
      end else if (load_m_skid) begin
        m_data <= s_data;
        m_err  <= s_err;
        m_tag  <= s_tag;
      end
      if (load_s) begin
        s_data <= dec_data;
        s_err  <= dec_err;
        s_tag  <= bus.i_tag;
      end
    end
  end

  assign bus.o_valid    = out_valid;
  assign bus.o_ready    = st_ready & rdy_en;
  assign bus.o_imm_data = m_data;
  assign bus.o_imm_err  = m_err;
  assign bus.o_tag      = m_tag;

endmodule
